// File: rtl/sseg_value_display.sv
// ---------------------------------------------------------------------------
// sseg_value_display
//
// Output stage of the sawtooth counter top. Converts an 8-bit (DATA_W-bit)
// value into three decimal digits with a sequential double-dabble, and drives
// four seven-segment displays: sseg0..sseg2 show ones/tens/hundreds of the
// value and sseg3 shows the 3-bit FSM state code. A single-entry pending
// buffer holds a load that arrives while a conversion is running, so updates
// are never lost (the most recent one wins).
//
// Parameters:
//   DATA_W         - binary input width, 1..9 (result fits in 3 BCD digits)
//   SEG_ACTIVE_LOW - 1: segment lit by 0 (board default); 0: inverted outputs
//
// Ports:
//   clk_i    - system clock
//   rst_i    - synchronous active-low reset
//   load_i   - single-cycle request to display value_i / state_i
//   value_i  - binary value to display
//   state_i  - FSM state code shown on sseg3
//   busy_o   - high while a conversion is in progress
//   done_o   - one-cycle pulse coincident with the display update
//   sseg0..3 - segment outputs {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module sseg_value_display #(
    parameter int DATA_W         = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic [2:0]        state_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [6:0]        sseg0,
    output logic [6:0]        sseg1,
    output logic [6:0]        sseg2,
    output logic [6:0]        sseg3
);

    localparam logic [3:0] DATA_W_CNT = 4'(DATA_W);
    localparam logic [6:0] SEG_BLANK  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [11:0]       bcd_adj;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        st_latch_q, st_latch_d;
    logic              pend_flag_q, pend_flag_d;
    logic [DATA_W-1:0] pend_val_q, pend_val_d;
    logic [2:0]        pend_st_q, pend_st_d;
    logic              done_q, done_d;
    logic [6:0]        sseg0_q, sseg0_d;
    logic [6:0]        sseg1_q, sseg1_d;
    logic [6:0]        sseg2_q, sseg2_d;
    logic [6:0]        sseg3_q, sseg3_d;

    // Double-dabble correction: a nibble of 5..9 would become >= 10 after the
    // shift, so adding 3 first makes the carry land in the next nibble.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    // Active-low glyph table, inverted when the board drives segments high.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic blank);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b1111111;
        endcase
        if (blank) begin
            code = 7'b1111111;
        end
        return SEG_ACTIVE_LOW ? code : ~code;
    endfunction

    always_comb begin
        bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    end

    // Next-state logic. The display registers only change in DONE, so the
    // scratch register is never visible while it holds partial results.
    // In DONE a new load outranks the pending entry (latest data wins).
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        st_latch_d  = st_latch_q;
        pend_flag_d = pend_flag_q;
        pend_val_d  = pend_val_q;
        pend_st_d   = pend_st_q;
        done_d      = 1'b0;
        sseg0_d     = sseg0_q;
        sseg1_d     = sseg1_q;
        sseg2_d     = sseg2_q;
        sseg3_d     = sseg3_q;

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    bin_d      = value_i;
                    st_latch_d = state_i;
                    bcd_d      = 12'd0;
                    cnt_d      = DATA_W_CNT;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
                if (load_i) begin
                    pend_flag_d = 1'b1;
                    pend_val_d  = value_i;
                    pend_st_d   = state_i;
                end
            end

            DONE: begin
                done_d  = 1'b1;
                sseg0_d = seg_encode(bcd_q[3:0], 1'b0);
                sseg1_d = seg_encode(bcd_q[7:4], (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0));
                sseg2_d = seg_encode(bcd_q[11:8], bcd_q[11:8] == 4'd0);
                sseg3_d = seg_encode({1'b0, st_latch_q}, 1'b0);
                if (load_i || pend_flag_q) begin
                    bin_d       = load_i ? value_i : pend_val_q;
                    st_latch_d  = load_i ? state_i : pend_st_q;
                    bcd_d       = 12'd0;
                    cnt_d       = DATA_W_CNT;
                    pend_flag_d = 1'b0;
                    state_d     = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset drops any
    // in-flight conversion and pending request and blanks the display.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            st_latch_q  <= '0;
            pend_flag_q <= 1'b0;
            pend_val_q  <= '0;
            pend_st_q   <= '0;
            done_q      <= 1'b0;
            sseg0_q     <= SEG_BLANK;
            sseg1_q     <= SEG_BLANK;
            sseg2_q     <= SEG_BLANK;
            sseg3_q     <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            st_latch_q  <= st_latch_d;
            pend_flag_q <= pend_flag_d;
            pend_val_q  <= pend_val_d;
            pend_st_q   <= pend_st_d;
            done_q      <= done_d;
            sseg0_q     <= sseg0_d;
            sseg1_q     <= sseg1_d;
            sseg2_q     <= sseg2_d;
            sseg3_q     <= sseg3_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign sseg0  = sseg0_q;
    assign sseg1  = sseg1_q;
    assign sseg2  = sseg2_q;
    assign sseg3  = sseg3_q;

endmodule
